// File: rtl/level_sensor_conditioner.sv
// rtl/level_sensor_conditioner.sv - sync/debounce of level and pump-fault inputs plus fault-encoding FSM
// Optional build macro: LSC_STICKY_FAULT_EN (recovery to normal needs operator fault_clr).
module level_sensor_conditioner #(
  parameter int DEB_CYCLES = 8,
  parameter int CNT_W      = 4,
  parameter int FAULT_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [1:0] raw_lvl,
  input  logic [1:0] raw_flt,
  input  logic       fault_clr,
  output logic [1:0] A,
  output logic [1:0] P,
  output logic       lvl_chg
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {ST_OK, ST_FLT0, ST_FLT1, ST_RECOV} state_t;

  // bits [1:0] level probes, [3:2] pump faults
  logic [3:0]       r_sync1, r_sync2, r_stable, w_stable_nxt;
  logic [CNT_W-1:0] r_cnt [4];
  logic [CNT_W-1:0] w_cnt_nxt [4];
  logic             r_lvl_chg;
  state_t           r_state, w_state_nxt;
  logic [1:0]       r_p, w_p_nxt;
  logic [CNT_W-1:0] r_hold, w_hold_nxt;
  logic [1:0]       w_df;

  assign w_df = r_stable[3:2];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= {raw_flt, raw_lvl};
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_stable_nxt = r_stable;
    for (int i = 0; i < 4; i++) begin
      w_cnt_nxt[i] = r_cnt[i];
      if (r_sync2[i] == r_stable[i]) begin
        w_cnt_nxt[i] = '0;
      end else if (sample_en) begin
        if (r_cnt[i] >= DEB_LAST) begin
          w_stable_nxt[i] = r_sync2[i];
          w_cnt_nxt[i]    = '0;
        end else if (r_cnt[i] != CNT_MAX) begin
          w_cnt_nxt[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stable  <= '0;
      r_lvl_chg <= 1'b0;
      for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
    end else begin
      r_stable  <= w_stable_nxt;
      r_lvl_chg <= |(w_stable_nxt[1:0] ^ r_stable[1:0]);
      for (int i = 0; i < 4; i++) r_cnt[i] <= w_cnt_nxt[i];
    end
  end

  // Pump 0 wins whenever both pumps report a fault, so P can never read 11.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_OK: begin
        if (w_df[0])      w_state_nxt = ST_FLT0;
        else if (w_df[1]) w_state_nxt = ST_FLT1;
      end
      ST_FLT0: begin
        if (w_df == 2'b00) begin
          w_state_nxt = ST_RECOV;
          w_hold_nxt  = '0;
        end else if (w_df == 2'b10) begin
          w_state_nxt = ST_FLT1;
        end
      end
      ST_FLT1: begin
        if (w_df[0]) begin
          w_state_nxt = ST_FLT0;
        end else if (w_df == 2'b00) begin
          w_state_nxt = ST_RECOV;
          w_hold_nxt  = '0;
        end
      end
      ST_RECOV: begin
        if (w_df[0]) begin
          w_state_nxt = ST_FLT0;
          w_hold_nxt  = '0;
        end else if (w_df[1]) begin
          w_state_nxt = ST_FLT1;
          w_hold_nxt  = '0;
        end else if (sample_en) begin
          if (r_hold >= HOLD_LAST) begin
`ifdef LSC_STICKY_FAULT_EN
            if (fault_clr) begin
              w_state_nxt = ST_OK;
              w_hold_nxt  = '0;
            end
`else
            w_state_nxt = ST_OK;
            w_hold_nxt  = '0;
`endif
          end else begin
            w_hold_nxt = r_hold + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_OK;
        w_hold_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_p_nxt = r_p;
    case (w_state_nxt)
      ST_OK:    w_p_nxt = 2'b00;
      ST_FLT0:  w_p_nxt = 2'b01;
      ST_FLT1:  w_p_nxt = 2'b10;
      default:  w_p_nxt = r_p;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_OK;
      r_hold  <= '0;
      r_p     <= 2'b00;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
      r_p     <= w_p_nxt;
    end
  end

`ifndef LSC_STICKY_FAULT_EN
  logic w_unused_fault_clr;
  assign w_unused_fault_clr = fault_clr;
`endif

  assign A       = r_stable[1:0];
  assign P       = r_p;
  assign lvl_chg = r_lvl_chg;

endmodule
